// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Writer side of the instruction-memory / PC interface. Accepts a
//             program as a byte stream (valid/ready), packs bytes MSB first
//             into 32-bit words and writes them to instruction memory starting
//             at a relocation base. Holds the PC frozen (Carregando) while a
//             load is in progress.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock           in   1   system clock, posedge
//    Reset           in   1   synchronous, active-high
//    Iniciar         in   1   start request, sampled only when idle
//    Offset          in   32  word base address, latched on accepted start
//    Num_Palavras    in   16  word count, latched on accepted start
//    Byte_In         in   8   stream data byte
//    Byte_Valid      in   1   Byte_In valid
//    Byte_Ready      out   1   loader accepts a byte this cycle
//    Mem_We          out   1   instruction memory write strobe (1 cycle/word)
//    Mem_Addr        out   32  word address = latched Offset + word index
//    Mem_Dado        out   32  assembled word
//    Carregando      out   1   load in progress, freezes the PC
//    Carga_Concluida out   1   1-cycle pulse, all words written
//    Erro_Carga      out   1   1-cycle pulse, rejected start or timeout abort
// ============================================================================
module program_loader #(
    parameter int MEM_DEPTH   = 1024,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Iniciar,
    input  logic [31:0] Offset,
    input  logic [15:0] Num_Palavras,
    input  logic [7:0]  Byte_In,
    input  logic        Byte_Valid,
    output logic        Byte_Ready,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Dado,
    output logic        Carregando,
    output logic        Carga_Concluida,
    output logic        Erro_Carga
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [31:0]     offset_lat;
    logic [15:0]     num_lat;
    logic [15:0]     word_idx;
    logic [1:0]      byte_idx;
    logic [23:0]     word_acc;     // first three bytes of the word being built
    logic [TW-1:0]   tmo_cnt;
    logic [31:0]     addr_q;
    logic [31:0]     dado_q;

    logic [32:0]     end_addr;
    logic            out_of_bounds;
    logic            accept;
    logic            last_byte;
    logic            tmo_expired;
    logic            last_word;

    // 33-bit sum so a huge Offset cannot wrap past the depth check.
    assign end_addr      = {1'b0, Offset} + {17'b0, Num_Palavras};
    assign out_of_bounds = end_addr > 33'(MEM_DEPTH);
    assign accept        = Byte_Ready && Byte_Valid;
    assign last_byte     = (byte_idx == 2'd3);
    // Transition happens on the idle cycle that would make the count reach
    // TIMEOUT_CYC, so the ERR cycle follows exactly TIMEOUT_CYC idle cycles.
    assign tmo_expired   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign last_word     = (word_idx == num_lat - 16'd1);

    // Address/data are registered so they hold their last value outside WRITE.
    assign Mem_Addr = addr_q;
    assign Mem_Dado = dado_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        Byte_Ready      = 1'b0;
        Mem_We          = 1'b0;
        Carregando      = 1'b0;
        Carga_Concluida = 1'b0;
        Erro_Carga      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Iniciar) begin
                    if (out_of_bounds) begin
                        state_nx = S_ERR;
                    end else if (Num_Palavras == 16'd0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RECV;
                    end
                end
            end
            S_RECV: begin
                Byte_Ready = 1'b1;
                Carregando = 1'b1;
                if (Byte_Valid) begin
                    if (last_byte) begin
                        state_nx = S_WRITE;
                    end
                end else if (tmo_expired) begin
                    state_nx = S_ERR;
                end
            end
            S_WRITE: begin
                Mem_We     = 1'b1;
                Carregando = 1'b1;
                state_nx   = last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                Carga_Concluida = 1'b1;
                state_nx        = S_IDLE;
            end
            S_ERR: begin
                Erro_Carga = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            offset_lat <= 32'd0;
            num_lat    <= 16'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            word_acc   <= 24'd0;
            tmo_cnt    <= '0;
            addr_q     <= 32'd0;
            dado_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Iniciar && !out_of_bounds && (Num_Palavras != 16'd0)) begin
                        offset_lat <= Offset;
                        num_lat    <= Num_Palavras;
                        word_idx   <= 16'd0;
                        byte_idx   <= 2'd0;
                        tmo_cnt    <= '0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        word_acc <= {word_acc[15:0], Byte_In};
                        tmo_cnt  <= '0;
                        if (last_byte) begin
                            addr_q <= offset_lat + {16'd0, word_idx};
                            dado_q <= {word_acc, Byte_In};
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    tmo_cnt  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
